light_pattern_gen: RTL and testbench

Synthesizable pattern source for the bike light's output mux. It replaces the free-running behavioural blink/dim clocks with clock-enable-driven counters on the system clock. It produces a 50%-duty blink waveform and a PWM dim waveform. Both feed the one-hot mode select downstream of the ring counter.

---
 rtl/lightpkg.sv | 17 +
 rtl/mod_counter.sv | 36 +++
 rtl/light_pattern_gen.sv | 138 +++++++++++++
 tb/tb_light_pattern_gen.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/lightpkg.sv
// Shared bike-light definitions: output mode encodings and pattern generator defaults.
package lightpkg;

  // One-hot so the output mux can select directly on the mode bits.
  typedef enum logic [3:0] {
    s_OFF   = 4'b0001,
    s_ON    = 4'b0010,
    s_BLINK = 4'b0100,
    s_DIM   = 4'b1000
  } light_mode_e;

  localparam int unsigned LgPrescale       = 4;
  localparam int unsigned LgPwmW           = 2;
  localparam int unsigned LgBlinkPeriods   = 2;
  localparam int unsigned LgDimDutyDefault = 1;

endpackage

// File: rtl/mod_counter.sv
// Modulo counter with count enable, synchronous clear and a terminal-count strobe.
module mod_counter #(
  parameter int unsigned Width    = 2,
  parameter int unsigned MaxCount = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [Width-1:0] cnt,
  output logic             tc
);

  logic [Width-1:0] cnt_d, cnt_q;

  assign cnt = cnt_q;
  assign tc  = en & (cnt_q == Width'(MaxCount));

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tc) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/light_pattern_gen.sv
// Blink and PWM dim pattern source driven by clock-enable counters on the system clock.
// Optional LIGHTGEN_BREATHE_EN adds a breathe input that ramps the dim duty up and down.
module light_pattern_gen
  import lightpkg::*;
#(
  parameter int unsigned PRESCALE         = LgPrescale,
  parameter int unsigned PWM_W            = LgPwmW,
  parameter int unsigned BLINK_PERIODS    = LgBlinkPeriods,
  parameter int unsigned DIM_DUTY_DEFAULT = LgDimDutyDefault
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  input  logic [PWM_W:0] duty,
`ifdef LIGHTGEN_BREATHE_EN
  input  logic           breathe,
`endif
  output logic           blink,
  output logic           dim,
  output logic           pwm_wrap
);

  localparam int unsigned PreW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned BlinkW = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
  localparam int unsigned DutyW  = PWM_W + 1;
  localparam int unsigned PwmMax = (1 << PWM_W) - 1;
  localparam logic [PWM_W:0] DefDuty  = DutyW'(DIM_DUTY_DEFAULT);
  localparam logic [PWM_W:0] FullDuty = DutyW'(1 << PWM_W);

  logic [PreW-1:0]   pre_cnt;
  logic [PWM_W-1:0]  pwm_cnt;
  logic [BlinkW-1:0] blink_cnt;
  logic              tick, wrap, blink_tc, clr;
  logic [PWM_W:0]    duty_d, duty_q;
  logic              blink_q, dim_q, wrap_q;

  assign clr = ~enable;

  mod_counter #(
    .Width    (PreW),
    .MaxCount (PRESCALE - 1)
  ) u_pre (
    .clk   (clk),
    .reset (reset),
    .en    (enable),
    .clr   (clr),
    .cnt   (pre_cnt),
    .tc    (tick)
  );

  mod_counter #(
    .Width    (PWM_W),
    .MaxCount (PwmMax)
  ) u_pwm (
    .clk   (clk),
    .reset (reset),
    .en    (tick),
    .clr   (clr),
    .cnt   (pwm_cnt),
    .tc    (wrap)
  );

  mod_counter #(
    .Width    (BlinkW),
    .MaxCount (BLINK_PERIODS - 1)
  ) u_blink (
    .clk   (clk),
    .reset (reset),
    .en    (wrap),
    .clr   (clr),
    .cnt   (blink_cnt),
    .tc    (blink_tc)
  );

`ifdef LIGHTGEN_BREATHE_EN
  logic dir_up_d, dir_up_q;

  // Triangle ramp 0..FullDuty; direction flips when an end value is reached.
  always_comb begin
    duty_d   = duty_q;
    dir_up_d = dir_up_q;
    if (wrap) begin
      if (!breathe) begin
        duty_d = duty;
      end else if (dir_up_q && (duty_q >= FullDuty)) begin
        dir_up_d = 1'b0;
        duty_d   = duty_q - DutyW'(1);
      end else if (!dir_up_q && (duty_q == '0)) begin
        dir_up_d = 1'b1;
        duty_d   = duty_q + DutyW'(1);
      end else if (dir_up_q) begin
        duty_d = duty_q + DutyW'(1);
      end else begin
        duty_d = duty_q - DutyW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_up_q <= 1'b1;
    end else begin
      dir_up_q <= dir_up_d;
    end
  end
`else
  // Shadowed so a mid-period duty change only takes effect at the next period.
  always_comb begin
    duty_d = duty_q;
    if (wrap) begin
      duty_d = duty;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_q  <= DefDuty;
      blink_q <= 1'b0;
      dim_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      wrap_q <= wrap;
      dim_q  <= enable & ({1'b0, pwm_cnt} < duty_q);
      if (!enable) begin
        blink_q <= 1'b0;
      end else if (blink_tc) begin
        blink_q <= ~blink_q;
      end
    end
  end

  assign blink    = blink_q;
  assign dim      = dim_q;
  assign pwm_wrap = wrap_q;

endmodule

// File: tb/tb_light_pattern_gen.sv
// Self-checking bench for light_pattern_gen against an arithmetic phase model.
module tb_light_pattern_gen;

  localparam int P    = 4;
  localparam int PER  = 4;
  localparam int BP   = 2;
  localparam int PWMP = P * PER;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [2:0] duty;
  logic       blink, dim, pwm_wrap;
`ifdef LIGHTGEN_BREATHE_EN
  logic       breathe;
`endif

  int compared   = 0;
  int mismatched = 0;

  // Model state: enabled-cycle count since (re)start, shadow duty, ramp direction.
  int n, dq;
  bit up, eb, ed, ew;

  always #5 clk = ~clk;

  light_pattern_gen dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .duty     (duty),
`ifdef LIGHTGEN_BREATHE_EN
    .breathe  (breathe),
`endif
    .blink    (blink),
    .dim      (dim),
    .pwm_wrap (pwm_wrap)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0b expected %0b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    n  = 0;
    dq = 1;
    up = 1'b1;
    eb = 1'b0;
    ed = 1'b0;
    ew = 1'b0;
  endtask

  task automatic step(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      bit br;
      br = 1'b0;
`ifdef LIGHTGEN_BREATHE_EN
      br = breathe;
`endif
      if (!enable) begin
        n  = 0;
        ed = 1'b0;
        ew = 1'b0;
        eb = 1'b0;
      end else begin
        int  pwm;
        bit  wr;
        pwm = (n / P) % PER;
        wr  = (n % PWMP) == PWMP - 1;
        ed  = pwm < dq;
        ew  = wr;
        if (wr) begin
          if (br) begin
            if (up && dq >= PER) up = 1'b0;
            else if (!up && dq == 0) up = 1'b1;
            dq = up ? dq + 1 : dq - 1;
          end else begin
            dq = int'(duty);
          end
        end
        n++;
        eb = (((n / PWMP) / BP) % 2) == 1;
      end
      @(posedge clk);
      #1;
      chk("blink", blink, eb);
      chk("dim", dim, ed);
      chk("pwm_wrap", pwm_wrap, ew);
    end
  endtask

  initial begin
    int guard;
    reset  = 1'b1;
    enable = 1'b1;
    duty   = 3'd1;
`ifdef LIGHTGEN_BREATHE_EN
    breathe = 1'b0;
`endif
    model_reset();

    // Outputs held low during reset.
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("reset_blink", blink, 1'b0);
      chk("reset_dim", dim, 1'b0);
      chk("reset_wrap", pwm_wrap, 1'b0);
    end
    reset = 1'b0;

    // Duty 1: 4 high / 12 low per 16 clk; then free run for blink.
    step(16);
    step(128);

    // Mid-period duty change only lands at the next wrap.
    step(6);
    duty = 3'd3;
    step(42);

    // Duty extremes.
    duty = 3'd0;
    step(16 + 64);
    duty = 3'd4;
    step(16 + 64);
    duty = 3'd1;
    step(16);

    // Enable dropped mid-period; duty input changed while off must not reach duty_q.
    step(4);
    enable = 1'b0;
    duty   = 3'd2;
    step(10);
    enable = 1'b1;
    step(40);

    // Async reset while blink is high.
    duty  = 3'd3;
    guard = 0;
    while (!eb && guard < 200) begin
      step(1);
      guard++;
    end
    chk("blink_high_reached", eb, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_blink", blink, 1'b0);
    chk("async_dim", dim, 1'b0);
    chk("async_wrap", pwm_wrap, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(40);

    // Randomised duty and enable activity.
    for (int i = 0; i < 250; i++) begin
      duty   = 3'($urandom_range(0, 7));
      enable = ($urandom_range(0, 5) != 0);
      step($urandom_range(1, 24));
    end
    enable = 1'b1;
    step(32);

`ifdef LIGHTGEN_BREATHE_EN
    reset = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    reset   = 1'b0;
    duty    = 3'd1;
    breathe = 1'b1;
    step(PWMP * 12);
    breathe = 1'b0;
    duty    = 3'd2;
    step(PWMP * 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
